// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
//   mode_t       : detection mode, overlapping or non-overlapping
//   fill_state_t : decoded fill state, for waveform and debug
//   fill_w()     : width of a counter that holds 0..pat_w
package seq_det_pkg;

  typedef enum logic {
    MODE_OVERLAP    = 1'b0,
    MODE_NONOVERLAP = 1'b1
  } mode_t;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } fill_state_t;

  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock   : rising-edge clock
//   reset_b : synchronous active-low reset
//   clr     : clear to zero, wins over inc
//   inc     : increment by one, holds at all-ones
//   q       : count value
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_b,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// Serial bit-pattern detector with run-time loadable pattern.
//   clock     : rising-edge clock
//   reset_b   : synchronous active-low reset
//   en        : sample strobe for In
//   In        : serial data bit
//   mode      : MODE_OVERLAP / MODE_NONOVERLAP
//   load      : load pat_in as the pattern, restarts filling
//   pat_in    : new pattern value
//   cnt_clr   : clear the match counter
//   Out       : registered one-cycle match pulse
//   match_cnt : saturating match count
//
// state   | meaning
// FILLING | fewer than PAT_W bits sampled since reset/load/non-overlap hit
// ARMED   | history holds PAT_W valid bits, compare is live
module seq_detect_fsm
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011),
  parameter int unsigned      COUNT_W     = 8
) (
  input  logic               clock,
  input  logic               reset_b,
  input  logic               en,
  input  logic               In,
  input  mode_t              mode,
  input  logic               load,
  input  logic [PAT_W-1:0]   pat_in,
  input  logic               cnt_clr,
  output logic               Out,
  output logic [COUNT_W-1:0] match_cnt
);

  localparam int FILL_W = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist, hist_n;
  logic [PAT_W-1:0]  pat_r, pat_n;
  logic [FILL_W-1:0] fill, fill_n, fill_inc;
  logic              out_n;
  logic              hit;
  fill_state_t       fill_state;

  // state register
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      hist  <= '0;
      fill  <= '0;
      pat_r <= DEFAULT_PAT;
      Out   <= 1'b0;
    end else begin
      hist  <= hist_n;
      fill  <= fill_n;
      pat_r <= pat_n;
      Out   <= out_n;
    end
  end

  // next state
  always_comb begin
    hist_n   = hist;
    fill_n   = fill;
    pat_n    = pat_r;
    out_n    = 1'b0;
    hit      = 1'b0;
    fill_inc = (fill_state == ARMED) ? fill : fill + 1'b1;
    if (load) begin
      // the bit presented alongside a load is dropped
      pat_n  = pat_in;
      hist_n = '0;
      fill_n = '0;
    end else if (en) begin
      hist_n = {hist[PAT_W-2:0], In};
      // fill gate keeps a zero pattern from matching the reset history
      hit    = (fill_inc == FILL_FULL) && (hist_n == pat_r);
      out_n  = hit;
      fill_n = (hit && (mode == MODE_NONOVERLAP)) ? '0 : fill_inc;
    end
  end

  // decoded state
  always_comb begin
    fill_state = (fill == FILL_FULL) ? ARMED : FILLING;
  end

  // counts on the edge that raises Out
  sat_counter #(
    .W(COUNT_W)
  ) u_match_cnt (
    .clock   (clock),
    .reset_b (reset_b),
    .clr     (cnt_clr),
    .inc     (out_n),
    .q       (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm. Two instances share stimulus: one with
// an 8-bit counter and one with a 2-bit counter to reach saturation quickly.
// A queue-based model of the sampled stream is checked every cycle.
module tb_seq_detect_fsm;
  import seq_det_pkg::*;

  logic       clock   = 1'b0;
  logic       reset_b = 1'b0;
  logic       en      = 1'b0;
  logic       In      = 1'b0;
  logic       load    = 1'b0;
  logic       cnt_clr = 1'b0;
  mode_t      mode    = MODE_OVERLAP;
  logic [3:0] pat_in  = 4'b0000;

  logic       out8, out2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  seq_detect_fsm #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .COUNT_W(8)) dut (
    .clock(clock), .reset_b(reset_b), .en(en), .In(In), .mode(mode),
    .load(load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .Out(out8), .match_cnt(cnt8)
  );

  seq_detect_fsm #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .COUNT_W(2)) dut_sat (
    .clock(clock), .reset_b(reset_b), .en(en), .In(In), .mode(mode),
    .load(load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .Out(out2), .match_cnt(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // model: bits sampled since reset/load/non-overlap hit, newest at back
  bit         q[$];
  logic [3:0] m_pat;
  bit         m_out;
  int         m_cnt8, m_cnt2;
  bit         m_valid = 1'b0;

  always @(posedge clock) begin
    if (!reset_b) begin
      q.delete();
      m_pat   = 4'b1011;
      m_out   = 1'b0;
      m_cnt8  = 0;
      m_cnt2  = 0;
      m_valid = 1'b1;
    end else begin
      m_out = 1'b0;
      if (load) begin
        m_pat = pat_in;
        q.delete();
      end else if (en) begin
        q.push_back(In);
        if (q.size() > 4) void'(q.pop_front());
        if (q.size() == 4 && {q[0], q[1], q[2], q[3]} == m_pat) begin
          m_out = 1'b1;
          if (mode == MODE_NONOVERLAP) q.delete();
        end
      end
      if (cnt_clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (m_out) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_out8", {31'b0, out8}, {31'b0, m_out});
      chk("model_out2", {31'b0, out2}, {31'b0, m_out});
      chk("model_cnt8", {24'b0, cnt8}, m_cnt8);
      chk("model_cnt2", {30'b0, cnt2}, m_cnt2);
    end
  end

  task automatic cyc(input logic r, input logic e, input logic i,
                     input logic l = 1'b0, input logic c = 1'b0,
                     input logic [3:0] p = 4'b0000);
    reset_b = r;
    en      = e;
    In      = i;
    load    = l;
    cnt_clr = c;
    pat_in  = p;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  // feed n bits MSB-first, checking Out after each edge against exp_out
  task automatic bits(input string name, input logic [15:0] stream, input int n,
                      input logic [15:0] exp_out);
    logic [15:0] s, e;
    s = stream;
    e = exp_out;
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, 1'b1, s[n-1-k]);
      chk(name, {31'b0, out8}, {31'b0, e[n-1-k]});
    end
  endtask

  logic [1:0] exp_sat [7];

  initial begin
    exp_sat = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

    do_reset();
    chk("reset_out", {31'b0, out8}, 32'd0);
    chk("reset_cnt", {24'b0, cnt8}, 32'd0);

    // 1: overlap
    mode = MODE_OVERLAP;
    bits("t1_out", 16'b1011011, 7, 16'b0001001);
    chk("t1_cnt", {24'b0, cnt8}, 32'd2);
    chk("t1_model_cnt", m_cnt8, 32'd2);

    // 2: non-overlap
    do_reset();
    mode = MODE_NONOVERLAP;
    bits("t2_out", 16'b10110111011, 11, 16'b00010000001);
    chk("t2_cnt", {24'b0, cnt8}, 32'd2);

    // 3a: gap in the stream
    do_reset();
    mode = MODE_OVERLAP;
    bits("t3a_pre", 16'b10, 2, 16'b00);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b1);
      chk("t3a_gap", {31'b0, out8}, 32'd0);
    end
    bits("t3a_post", 16'b11, 2, 16'b01);
    chk("t3a_cnt", {24'b0, cnt8}, 32'd1);

    // 3b: reset mid-stream
    do_reset();
    bits("t3b_pre", 16'b101, 3, 16'b000);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t3b_rst", {31'b0, out8}, 32'd0);
    bits("t3b_post", 16'b1, 1, 16'b0);
    chk("t3b_cnt", {24'b0, cnt8}, 32'd0);

    // 4: load mid-stream, bit on the load edge discarded
    do_reset();
    bits("t4_pre", 16'b101, 3, 16'b000);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110);
    chk("t4_load", {31'b0, out8}, 32'd0);
    bits("t4_post", 16'b0110, 4, 16'b0001);
    chk("t4_cnt", {24'b0, cnt8}, 32'd1);

    // 5: saturation and clear priority
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, 1'b1, 1'b1);
      chk("t5_out", {31'b0, out2}, (k >= 3) ? 32'd1 : 32'd0);
      chk("t5_sat", {30'b0, cnt2}, {30'b0, exp_sat[k]});
    end
    chk("t5_cnt8", {24'b0, cnt8}, 32'd4);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_clr_out", {31'b0, out2}, 32'd1);
    chk("t5_clr_cnt2", {30'b0, cnt2}, 32'd0);
    chk("t5_clr_cnt8", {24'b0, cnt8}, 32'd0);

    // 6: all-zero pattern needs four real samples
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    bits("t6_out", 16'b0000, 4, 16'b0001);
    chk("t6_cnt", {24'b0, cnt8}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
